md_sequencer: RTL and testbench

- Multi-cycle multiply/divide sequencer for the pipelined MIPS CPU, sitting beside the E-stage ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E stage, holds HI/LO, and drives busy plus a stall request to the hazard logic.
- Serves MFHI/MFLO reads combinationally.
- Models fixed-latency units with a down-counter; the arithmetic result is computed at issue and committed at the end of the count.

---
 rtl/md_sequencer.sv | 175 +++++++++++++++++
 tb/tb_md_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/md_sequencer.sv
// Multi-cycle MULT/DIV sequencer beside the E-stage ALU; owns HI/LO and drives busy/stall.
// Optional build macro MD_MADD_EN: md_op 7 becomes MADD ({HI,LO} += signed rs*rt).
module md_sequencer #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        cancel,
  input  logic        d_is_md,
  input  logic        rd_sel,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic [31:0] md_rdata
);

  localparam int DATA_W = 32;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  if (MUL_CYCLES < 1 || MUL_CYCLES > 15) begin : g_bad_mul_cycles
    $error("md_sequencer: MUL_CYCLES must be in 1..15");
  end
  if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_div_cycles
    $error("md_sequencer: DIV_CYCLES must be in 1..15");
  end

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                state, state_nx;
  logic [3:0]            cnt, cnt_nx;
  logic [DATA_W-1:0]     hi, lo, hi_nx, lo_nx;
  logic [DATA_W-1:0]     hi_t, lo_t, hi_t_nx, lo_t_nx;
  logic                  wr_t, wr_t_nx;
  logic [2*DATA_W-1:0]   res;
  logic                  is_mul, is_div, is_madd, long_op;

  function automatic logic [63:0] mul_s(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ax, bx;
    ax = {{32{a[31]}}, a};
    bx = {{32{b[31]}}, b};
    return 64'(ax * bx);
  endfunction

  function automatic logic [63:0] mul_u(input logic [31:0] a, input logic [31:0] b);
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Returns {remainder, quotient}; a zero divisor yields zero (never committed).
  function automatic logic [63:0] div_u(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 64'd0;
    return {a % b, a / b};
  endfunction

  // Signed divide via magnitudes, so 0x80000000 / -1 wraps to 0x80000000 rem 0.
  function automatic logic [63:0] div_s(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    if (b == 32'd0) return 64'd0;
    ma = a[31] ? -a : a;
    mb = b[31] ? -b : b;
    q  = ma / mb;
    r  = ma % mb;
    if (a[31] ^ b[31]) q = -q;
    if (a[31]) r = -r;
    return {r, q};
  endfunction

  assign is_mul = (md_op == OP_MULT) || (md_op == OP_MULTU);
  assign is_div = (md_op == OP_DIV)  || (md_op == OP_DIVU);
`ifdef MD_MADD_EN
  assign is_madd = (md_op == 3'd7);
`else
  assign is_madd = 1'b0;
`endif
  assign long_op = start && (is_mul || is_div || is_madd);

  always_comb begin
    res = 64'd0;
    case (md_op)
      OP_MULT:  res = mul_s(rs_val, rt_val);
      OP_MULTU: res = mul_u(rs_val, rt_val);
      OP_DIV:   res = div_s(rs_val, rt_val);
      OP_DIVU:  res = div_u(rs_val, rt_val);
`ifdef MD_MADD_EN
      3'd7:     res = {hi, lo} + mul_s(rs_val, rt_val);
`endif
      default:  res = 64'd0;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    hi_nx    = hi;
    lo_nx    = lo;
    hi_t_nx  = hi_t;
    lo_t_nx  = lo_t;
    wr_t_nx  = wr_t;
    case (state)
      IDLE: begin
        if (start && !cancel) begin
          if (long_op) begin
            hi_t_nx  = res[63:32];
            lo_t_nx  = res[31:0];
            wr_t_nx  = !(is_div && (rt_val == 32'd0));
            cnt_nx   = is_div ? 4'(DIV_CYCLES) : 4'(MUL_CYCLES);
            state_nx = BUSY;
          end else if (md_op == OP_MTHI) begin
            hi_nx = rs_val;
          end else if (md_op == OP_MTLO) begin
            lo_nx = rs_val;
          end
        end
      end
      BUSY: begin
        if (cancel) begin
          state_nx = IDLE;
          cnt_nx   = 4'd0;
          hi_t_nx  = '0;
          lo_t_nx  = '0;
          wr_t_nx  = 1'b0;
        end else if (cnt == 4'd1) begin
          if (wr_t) begin
            hi_nx = hi_t;
            lo_nx = lo_t;
          end
          state_nx = IDLE;
          cnt_nx   = 4'd0;
          wr_t_nx  = 1'b0;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      hi    <= '0;
      lo    <= '0;
      hi_t  <= '0;
      lo_t  <= '0;
      wr_t  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      hi    <= hi_nx;
      lo    <= lo_nx;
      hi_t  <= hi_t_nx;
      lo_t  <= lo_t_nx;
      wr_t  <= wr_t_nx;
    end
  end

  assign busy     = (state == BUSY);
  assign stall    = d_is_md && (busy || long_op);
  assign hi_out   = hi;
  assign lo_out   = lo;
  assign md_rdata = rd_sel ? hi : lo;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed self-checking bench for md_sequencer (default MUL_CYCLES=5, DIV_CYCLES=10).
module tb_md_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        cancel;
  logic        d_is_md;
  logic        rd_sel;
  logic        busy;
  logic        stall;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic [31:0] md_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  md_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .cancel   (cancel),
    .d_is_md  (d_is_md),
    .rd_sel   (rd_sel),
    .busy     (busy),
    .stall    (stall),
    .hi_out   (hi_out),
    .lo_out   (lo_out),
    .md_rdata (md_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one start cycle and leaves the bench one cycle after issue.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    tick();
    start = 1'b0; md_op = 3'd0;
  endtask

  // Counts consecutive busy cycles; stops on the first idle cycle or after 40.
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    int n;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_checks++; if (hi_out !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 00000000", hi_out); end
    n_checks++; if (lo_out !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 00000000", lo_out); end
    n_checks++; if (md_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 00000000", md_rdata); end
    reset = 1'b1;
    tick();
    issue(3'd5, 32'hAAAA0000, 32'd0);
    issue(3'd6, 32'h00005555, 32'd0);
    issue(3'd1, 32'd2, 32'd3);
    tick();
    #3 reset = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midbusy_reset_busy: got %0b want 0", busy); end
    n_checks++; if (hi_out !== 32'd0) begin n_fail++; $display("FAIL midbusy_reset_hi: got %h want 00000000", hi_out); end
    n_checks++; if (lo_out !== 32'd0) begin n_fail++; $display("FAIL midbusy_reset_lo: got %h want 00000000", lo_out); end
    tick();
    reset = 1'b1;
    tick();
    issue(3'd6, 32'h00001234, 32'd0);
    n_checks++; if (lo_out !== 32'h00001234) begin n_fail++; $display("FAIL mtlo_lo: got %h want 00001234", lo_out); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mtlo_busy: got %0b want 0", busy); end
    n_checks++; if (hi_out !== 32'd0) begin n_fail++; $display("FAIL mtlo_hi: got %h want 00000000", hi_out); end
    count_busy(n);
    n_checks++; if (n !== 0) begin n_fail++; $display("FAIL mtlo_busy_cycles: got %0d want 0", n); end
  endtask

  task automatic test_mult();
    int n;
    issue(3'd5, 32'h0BADF00D, 32'd0);
    issue(3'd1, 32'hFFFFFFFE, 32'd3);
    n_checks++; if (hi_out !== 32'h0BADF00D) begin n_fail++; $display("FAIL mult_no_bypass: got %h want 0badf00d", hi_out); end
    count_busy(n);
    n_checks++; if (n !== 5) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d want 5", n); end
    n_checks++; if (hi_out !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", hi_out); end
    n_checks++; if (lo_out !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL mult_lo: got %h want fffffffa", lo_out); end
    issue(3'd2, 32'hFFFFFFFE, 32'd3);
    count_busy(n);
    n_checks++; if (n !== 5) begin n_fail++; $display("FAIL multu_busy_cycles: got %0d want 5", n); end
    n_checks++; if (hi_out !== 32'h00000002) begin n_fail++; $display("FAIL multu_hi: got %h want 00000002", hi_out); end
    n_checks++; if (lo_out !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL multu_lo: got %h want fffffffa", lo_out); end
    rd_sel = 1'b1; #1;
    n_checks++; if (md_rdata !== 32'h00000002) begin n_fail++; $display("FAIL rdata_hi: got %h want 00000002", md_rdata); end
    rd_sel = 1'b0; #1;
    n_checks++; if (md_rdata !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL rdata_lo: got %h want fffffffa", md_rdata); end
  endtask

  task automatic test_div();
    int n;
    issue(3'd3, 32'hFFFFFFF9, 32'd2);
    count_busy(n);
    n_checks++; if (n !== 10) begin n_fail++; $display("FAIL div_busy_cycles: got %0d want 10", n); end
    n_checks++; if (lo_out !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_lo: got %h want fffffffd", lo_out); end
    n_checks++; if (hi_out !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_hi: got %h want ffffffff", hi_out); end
    issue(3'd5, 32'd5, 32'd0);
    issue(3'd6, 32'd6, 32'd0);
    issue(3'd4, 32'd7, 32'd0);
    count_busy(n);
    n_checks++; if (n !== 10) begin n_fail++; $display("FAIL divu0_busy_cycles: got %0d want 10", n); end
    n_checks++; if (hi_out !== 32'd5) begin n_fail++; $display("FAIL divu0_hi: got %h want 00000005", hi_out); end
    n_checks++; if (lo_out !== 32'd6) begin n_fail++; $display("FAIL divu0_lo: got %h want 00000006", lo_out); end
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    count_busy(n);
    n_checks++; if (lo_out !== 32'h80000000) begin n_fail++; $display("FAIL div_ovf_lo: got %h want 80000000", lo_out); end
    n_checks++; if (hi_out !== 32'd0) begin n_fail++; $display("FAIL div_ovf_hi: got %h want 00000000", hi_out); end
    issue(3'd4, 32'hFFFFFFF9, 32'd2);
    count_busy(n);
    n_checks++; if (lo_out !== 32'h7FFFFFFC) begin n_fail++; $display("FAIL divu_lo: got %h want 7ffffffc", lo_out); end
    n_checks++; if (hi_out !== 32'd1) begin n_fail++; $display("FAIL divu_hi: got %h want 00000001", hi_out); end
  endtask

  task automatic test_stall();
    d_is_md = 1'b1;
    start = 1'b1; md_op = 3'd3; rs_val = 32'd100; rt_val = 32'd7;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL stall_issue: got %0b want 1", stall); end
    tick();
    start = 1'b0; md_op = 3'd0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 3) begin
        start = 1'b1; md_op = 3'd1; rs_val = 32'd5; rt_val = 32'd5;
      end else begin
        start = 1'b0; md_op = 3'd0;
      end
      #1;
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL stall_busy_c%0d: got %0b want 1", c, stall); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_c%0d: got %0b want 1", c, busy); end
      tick();
    end
    start = 1'b0; md_op = 3'd0; #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL stall_end: got %0b want 0", stall); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_end: got %0b want 0", busy); end
    n_checks++; if (lo_out !== 32'd14) begin n_fail++; $display("FAIL div_ignore_lo: got %h want 0000000e", lo_out); end
    n_checks++; if (hi_out !== 32'd2) begin n_fail++; $display("FAIL div_ignore_hi: got %h want 00000002", hi_out); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_late: got %0b want 0", busy); end
    d_is_md = 1'b0;
    start = 1'b1; md_op = 3'd1; #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL stall_no_dmd: got %0b want 0", stall); end
    start = 1'b0; md_op = 3'd0; #1;
  endtask

  task automatic test_cancel();
    int n;
    issue(3'd5, 32'h11111111, 32'd0);
    issue(3'd6, 32'h22222222, 32'd0);
    issue(3'd1, 32'd3, 32'd4);
    tick();
    tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_busy: got %0b want 0", busy); end
    repeat (6) tick();
    n_checks++; if (hi_out !== 32'h11111111) begin n_fail++; $display("FAIL cancel_hi: got %h want 11111111", hi_out); end
    n_checks++; if (lo_out !== 32'h22222222) begin n_fail++; $display("FAIL cancel_lo: got %h want 22222222", lo_out); end
    cancel = 1'b1;
    issue(3'd5, 32'h0000DEAD, 32'd0);
    n_checks++; if (hi_out !== 32'h11111111) begin n_fail++; $display("FAIL start_cancel_mthi: got %h want 11111111", hi_out); end
    issue(3'd1, 32'd3, 32'd4);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_cancel_mult: got %0b want 0", busy); end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    n_checks++; if (lo_out !== 32'h22222222) begin n_fail++; $display("FAIL idle_cancel_lo: got %h want 22222222", lo_out); end
    issue(3'd1, 32'd3, 32'd4);
    count_busy(n);
    n_checks++; if (n !== 5) begin n_fail++; $display("FAIL post_cancel_cycles: got %0d want 5", n); end
    n_checks++; if (lo_out !== 32'd12) begin n_fail++; $display("FAIL post_cancel_lo: got %h want 0000000c", lo_out); end
    n_checks++; if (hi_out !== 32'd0) begin n_fail++; $display("FAIL post_cancel_hi: got %h want 00000000", hi_out); end
  endtask

  task automatic test_op7();
    int n;
    issue(3'd5, 32'd0, 32'd0);
    issue(3'd6, 32'hFFFFFFFF, 32'd0);
    d_is_md = 1'b1;
    start = 1'b1; md_op = 3'd7; rs_val = 32'd1; rt_val = 32'd1;
    #1;
`ifdef MD_MADD_EN
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL madd_stall: got %0b want 1", stall); end
    tick();
    start = 1'b0; md_op = 3'd0; d_is_md = 1'b0;
    count_busy(n);
    n_checks++; if (n !== 5) begin n_fail++; $display("FAIL madd_busy_cycles: got %0d want 5", n); end
    n_checks++; if (hi_out !== 32'd1) begin n_fail++; $display("FAIL madd_hi: got %h want 00000001", hi_out); end
    n_checks++; if (lo_out !== 32'd0) begin n_fail++; $display("FAIL madd_lo: got %h want 00000000", lo_out); end
`else
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL op7_stall: got %0b want 0", stall); end
    tick();
    start = 1'b0; md_op = 3'd0; d_is_md = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL op7_busy: got %0b want 0", busy); end
    repeat (6) tick();
    n_checks++; if (hi_out !== 32'd0) begin n_fail++; $display("FAIL op7_hi: got %h want 00000000", hi_out); end
    n_checks++; if (lo_out !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL op7_lo: got %h want ffffffff", lo_out); end
`endif
    issue(3'd0, 32'h12345678, 32'd1);
    count_busy(n);
    n_checks++; if (n !== 0) begin n_fail++; $display("FAIL op0_busy: got %0d want 0", n); end
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    md_op   = 3'd0;
    rs_val  = 32'd0;
    rt_val  = 32'd0;
    cancel  = 1'b0;
    d_is_md = 1'b0;
    rd_sel  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_mult();
    test_div();
    test_stall();
    test_cancel();
    test_op7();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
